// File: rtl/ram_multiport.sv
// ram_multiport: N-port word-addressed RAM with write-collision and out-of-bounds flags,
// configurable read latency, and per-byte write enables when RAM_MULTIPORT_BYTE_EN is defined.
module ram_multiport #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 101,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1,
  parameter int INIT_MODE    = 1
) (
  input  logic                            clock,
  input  logic                            sync_reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]            w_rq,
`ifdef RAM_MULTIPORT_BYTE_EN
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] w_be,
`endif
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_PORTS-1:0]            oob,
  output logic                            collision
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data_r [READ_LATENCY][NUM_PORTS];
  logic [NUM_PORTS-1:0]  pipe_oob_r [READ_LATENCY];
  logic                  collision_r;

  logic [ADDR_WIDTH-1:0] idx_s  [NUM_PORTS];
  logic [IDXW-1:0]       widx_s [NUM_PORTS];
  logic [BYTES-1:0]      be_s   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_s   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  inr_s;
  logic                  collision_s;

  // Address decode, bounds check, byte enables and old-contents read per port
  always_comb begin
    inr_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      idx_s[p]  = addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> SHIFT;
      widx_s[p] = idx_s[p][IDXW-1:0];
      inr_s[p]  = ({1'b0, idx_s[p]} < DEPTH_EXT);
`ifdef RAM_MULTIPORT_BYTE_EN
      be_s[p]   = w_be[p*BYTES +: BYTES];
`else
      be_s[p]   = '1;
`endif
      if (inr_s[p]) begin
        rd_s[p] = mem_r[widx_s[p]];
      end else begin
        rd_s[p] = '0;
      end
    end
  end

  // A collision needs two in-range writers to the same word sharing at least one enabled byte
  always_comb begin
    collision_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        collision_s = collision_s | (w_rq[p] & w_rq[q] & inr_s[p] & inr_s[q] &
                                     (idx_s[p] == idx_s[q]) & (|(be_s[p] & be_s[q])));
      end
    end
  end

  // Storage: init pattern on reset; later ports overwrite earlier ones byte-by-byte
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (INIT_MODE == 1) ? DATA_WIDTH'(i) : '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (w_rq[p] && inr_s[p] && be_s[p][b]) begin
            mem_r[widx_s[p]][b*8 +: 8] <= data_in[p*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  // Read pipeline (last stage is the output register) and collision flag register
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          pipe_data_r[s][p] <= '0;
        end
        pipe_oob_r[s] <= '0;
      end
      collision_r <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        pipe_data_r[0][p] <= rd_s[p];
      end
      pipe_oob_r[0] <= ~inr_s;
      for (int s = 1; s < READ_LATENCY; s++) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          pipe_data_r[s][p] <= pipe_data_r[s-1][p];
        end
        pipe_oob_r[s] <= pipe_oob_r[s-1];
      end
      collision_r <= collision_s;
    end
  end

  // Output packing from the final pipeline stage
  always_comb begin
    data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_out[p*DATA_WIDTH +: DATA_WIDTH] = pipe_data_r[READ_LATENCY-1][p];
    end
    oob       = pipe_oob_r[READ_LATENCY-1];
    collision = collision_r;
  end

endmodule

// File: tb/tb_ram_multiport.sv
// Directed self-checking bench for ram_multiport: a default instance (2 ports, latency 1)
// and a 4-port latency-3 instance; byte-enable scenario only when RAM_MULTIPORT_BYTE_EN is defined.
module tb_ram_multiport;

  logic          clock = 1'b0;
  logic          sync_reset = 1'b0;

  logic [63:0]   addr_a = '0;
  logic [63:0]   din_a  = '0;
  logic [1:0]    wrq_a  = '0;
  logic [63:0]   dout_a;
  logic [1:0]    oob_a;
  logic          coll_a;

  logic [127:0]  addr_b = '0;
  logic [127:0]  din_b  = '0;
  logic [3:0]    wrq_b  = '0;
  logic [127:0]  dout_b;
  logic [3:0]    oob_b;
  logic          coll_b;

`ifdef RAM_MULTIPORT_BYTE_EN
  logic [7:0]    be_a = '1;
  logic [15:0]   be_b = '1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  ram_multiport dut (
    .clock(clock), .sync_reset(sync_reset), .addr(addr_a), .data_in(din_a), .w_rq(wrq_a),
`ifdef RAM_MULTIPORT_BYTE_EN
    .w_be(be_a),
`endif
    .data_out(dout_a), .oob(oob_a), .collision(coll_a)
  );

  ram_multiport #(.NUM_PORTS(4), .READ_LATENCY(3)) dut3 (
    .clock(clock), .sync_reset(sync_reset), .addr(addr_b), .data_in(din_b), .w_rq(wrq_b),
`ifdef RAM_MULTIPORT_BYTE_EN
    .w_be(be_b),
`endif
    .data_out(dout_b), .oob(oob_b), .collision(coll_b)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    step();
    tests_run++;
    if (dout_a !== 64'd0) begin tests_failed++; $display("FAIL reset_dout_a: got %h expected 0", dout_a); end
    tests_run++;
    if (oob_a !== 2'b00) begin tests_failed++; $display("FAIL reset_oob_a: got %b expected 00", oob_a); end
    tests_run++;
    if (coll_a !== 1'b0) begin tests_failed++; $display("FAIL reset_coll_a: got %b expected 0", coll_a); end
    tests_run++;
    if (dout_b !== 128'd0 || oob_b !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_dut3: got %h/%b expected 0/0000", dout_b, oob_b);
    end
    sync_reset = 1'b0;
  endtask

  task automatic test_init_reads();
    logic [31:0] addrs [4];
    logic [31:0] exps [4];
    addrs = '{32'd0, 32'd4, 32'd8, 32'd400};
    exps  = '{32'd0, 32'd1, 32'd2, 32'd100};
    for (int i = 0; i < 4; i++) begin
      addr_a[31:0] = addrs[i];
      step();
      tests_run++;
      if (dout_a[31:0] !== exps[i] || oob_a[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL init_read[%0d]: got %0d oob %b expected %0d oob 0", i, dout_a[31:0], oob_a[0], exps[i]);
      end
    end
  endtask

  task automatic test_oob();
    addr_a[63:32] = 32'd404;
    step();
    tests_run++;
    if (dout_a[63:32] !== 32'd0 || oob_a[1] !== 1'b1) begin
      tests_failed++; $display("FAIL oob_read: got %h oob %b expected 0 oob 1", dout_a[63:32], oob_a[1]);
    end
    wrq_a = 2'b10;
    din_a[63:32] = 32'h0000dead;
    step();
    tests_run++;
    if (dout_a[63:32] !== 32'd0 || oob_a[1] !== 1'b1 || coll_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL oob_write: got %h oob %b coll %b expected 0 oob 1 coll 0", dout_a[63:32], oob_a[1], coll_a);
    end
    wrq_a = 2'b00;
    addr_a[63:32] = 32'd400;
    step();
    tests_run++;
    if (dout_a[63:32] !== 32'd100 || oob_a[1] !== 1'b0) begin
      tests_failed++; $display("FAIL oob_idx100: got %0d oob %b expected 100 oob 0", dout_a[63:32], oob_a[1]);
    end
  endtask

  task automatic test_collision();
    addr_a = {32'd12, 32'd12};
    din_a  = {32'h00000022, 32'h00000011};
    wrq_a  = 2'b11;
    step();
    tests_run++;
    if (coll_a !== 1'b1) begin tests_failed++; $display("FAIL coll_set: got %b expected 1", coll_a); end
    tests_run++;
    if (dout_a !== {32'd3, 32'd3}) begin
      tests_failed++; $display("FAIL coll_rdw_old: got %h expected 0000000300000003", dout_a);
    end
    wrq_a = 2'b00;
    step();
    tests_run++;
    if (coll_a !== 1'b0) begin tests_failed++; $display("FAIL coll_clear: got %b expected 0", coll_a); end
    tests_run++;
    if (dout_a !== {32'h22, 32'h22}) begin
      tests_failed++; $display("FAIL coll_winner: got %h expected 0000002200000022", dout_a);
    end
    // distinct in-range words, then same out-of-range word: neither is a collision
    addr_a = {32'd20, 32'd16};
    din_a  = {32'h00000088, 32'h00000077};
    wrq_a  = 2'b11;
    step();
    tests_run++;
    if (coll_a !== 1'b0) begin tests_failed++; $display("FAIL coll_distinct: got %b expected 0", coll_a); end
    addr_a = {32'd404, 32'd404};
    step();
    tests_run++;
    if (coll_a !== 1'b0 || oob_a !== 2'b11) begin
      tests_failed++; $display("FAIL coll_oob: got coll %b oob %b expected 0 11", coll_a, oob_a);
    end
    wrq_a  = 2'b00;
    addr_a = {32'd20, 32'd16};
    step();
    tests_run++;
    if (dout_a !== {32'h88, 32'h77}) begin
      tests_failed++; $display("FAIL distinct_readback: got %h expected 0000008800000077", dout_a);
    end
  endtask

  task automatic test_latency3();
    logic [31:0] exps [7];
    exps = '{32'd100, 32'd100, 32'd0, 32'd1, 32'd2, 32'd3, 32'd100};
    addr_b[127:96] = 32'd400;
    for (int i = 0; i < 3; i++) step();
    for (int j = 0; j < 7; j++) begin
      addr_b[127:96] = (j < 4) ? 32'(4 * j) : 32'd400;
      step();
      tests_run++;
      if (dout_b[127:96] !== exps[j] || oob_b[3] !== 1'b0) begin
        tests_failed++;
        $display("FAIL lat3_stream[%0d]: got %0d oob %b expected %0d oob 0", j, dout_b[127:96], oob_b[3], exps[j]);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] exps [3];
    exps = '{32'd0, 32'd0, 32'd5};
    addr_b[31:0] = 32'd20;
    din_b[31:0]  = 32'h00000055;
    wrq_b = 4'b0001;
    step();
    wrq_b = 4'b0000;
    step();
    sync_reset = 1'b1;
    step();
    tests_run++;
    if (dout_b[31:0] !== 32'd0 || oob_b !== 4'b0000 || coll_b !== 1'b0) begin
      tests_failed++; $display("FAIL flush_reset_edge: got %h oob %b expected 0 oob 0000", dout_b[31:0], oob_b);
    end
    sync_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (dout_b[31:0] !== exps[k]) begin
        tests_failed++; $display("FAIL flush_after[%0d]: got %h expected %h", k, dout_b[31:0], exps[k]);
      end
    end
  endtask

`ifdef RAM_MULTIPORT_BYTE_EN
  task automatic test_byte_en();
    addr_a = {32'd0, 32'd0};
    din_a  = {32'h11223344, 32'haabbccdd};
    be_a   = {4'b0110, 4'b0011};
    wrq_a  = 2'b11;
    step();
    tests_run++;
    if (coll_a !== 1'b1) begin tests_failed++; $display("FAIL be_coll: got %b expected 1", coll_a); end
    // disjoint enables on the same word: no overlap, no collision
    be_a = {4'b1000, 4'b0000};
    din_a = {32'h99000000, 32'h00000000};
    addr_a = {32'd4, 32'd4};
    step();
    tests_run++;
    if (coll_a !== 1'b0) begin tests_failed++; $display("FAIL be_disjoint: got %b expected 0", coll_a); end
    wrq_a  = 2'b00;
    be_a   = '1;
    addr_a = {32'd4, 32'd0};
    step();
    tests_run++;
    if (dout_a[31:0] !== 32'h002233dd) begin
      tests_failed++; $display("FAIL be_merge: got %h expected 002233dd", dout_a[31:0]);
    end
    tests_run++;
    if (dout_a[63:32] !== 32'h99000001) begin
      tests_failed++; $display("FAIL be_partial: got %h expected 99000001", dout_a[63:32]);
    end
  endtask
`endif

  initial begin
    step();
    test_reset();
    test_init_reads();
    test_oob();
    test_collision();
    test_latency3();
    test_reset_flush();
`ifdef RAM_MULTIPORT_BYTE_EN
    test_byte_en();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
